led_sequencer: RTL and testbench
================================

Name: led_sequencer

Overview:
- Parametrised successor to the single-pattern LED rotator.
- A prescaled step engine moves an NB_LEDS-wide pattern left, right, ping-pong (bounce) or holds it. The pattern is loadable at runtime.
- Sits between board push-button/config logic and the LED pins; o_led drives the pins directly.

Parameters:
- NB_LEDS, 4, pattern/LED width; must be >= 2.
- NB_COUNT, 8, prescaler counter width; step period is i_limit+1 enabled cycles.

Ports:
- clock  input  1  system clock, rising edge.
- i_reset  input  1  asynchronous, active-low reset.
- i_valid  input  1  enable; the prescaler advances only while high.
- i_mode  input  2  00 rotate left, 01 rotate right, 10 ping-pong, 11 hold.
- i_limit  input  NB_COUNT  prescaler terminal value.
- i_load  input  1  synchronous load strobe.
- i_pattern  input  NB_LEDS  value loaded on i_load.
- o_led  output  NB_LEDS  current pattern, registered.
- o_tick  output  1  one-cycle pulse, coincident with each pattern update.
- o_dir  output  1  current direction; 0 = left (towards MSB), 1 = right.

Behaviour:
- Reset (i_reset low, asynchronous): o_led = {0..0,1}, counter = 0, o_tick = 0, o_dir = 0 (state DIR_LEFT). Release is sampled on clock.
- All outputs are flops; no combinational path from inputs to outputs.
- Prescaler, when i_valid=1:
  - counter == i_limit -> counter <= 0, step fires.
  - otherwise counter <= counter+1.
- When i_valid=0, the counter holds and no step fires.
- i_limit=0 -> a step fires every enabled cycle.
- If i_limit is lowered below the current count, the counter wraps through 2^NB_COUNT back to i_limit. No special handling.
- Step (registered, visible the cycle after the terminal count): o_tick=1 for exactly one cycle. i_mode is sampled only on the step cycle.
- Rotate left: o_led <= {o_led[NB_LEDS-2:0], o_led[NB_LEDS-1]}; o_dir <= 0.
- Rotate right: o_led <= {o_led[0], o_led[NB_LEDS-1:1]}; o_dir <= 1.
- Ping-pong FSM, states DIR_LEFT / DIR_RIGHT:
  - DIR_LEFT with o_led[NB_LEDS-1]=1 -> go to DIR_RIGHT and shift right in the same step.
  - DIR_RIGHT with o_led[0]=1 -> go to DIR_LEFT and shift left in the same step.
  - Otherwise shift in the current direction.
  - Shifts are logical, zero-filled. Bits are not preserved for multi-hot patterns; that is intended.
  - One-hot sequence for NB_LEDS=4: 0001, 0010, 0100, 1000, 0100, 0010, 0001, 0010, ...
  - Period is 2*(NB_LEDS-1) steps.
- Hold: o_led and o_dir unchanged; o_tick still pulses.
- Load: i_load=1 -> o_led <= i_pattern, counter <= 0, o_tick <= 0, direction unchanged.
  - i_load has priority over a simultaneous step; that step is dropped.
  - i_load acts regardless of i_valid.
- All-zero pattern stays zero in every mode; ping-pong never flips on it.
- Switching into ping-pong resumes in the current o_dir.
- Reset mid-operation: immediate return to reset values, including during an o_tick cycle.

Decomposition:
- Package led_seq_pkg: mode encodings MODE_ROT_L=2'b00, MODE_ROT_R=2'b01, MODE_PING=2'b10, MODE_HOLD=2'b11; direction encodings DIR_LEFT=1'b0, DIR_RIGHT=1'b1.
- Sub-module step_prescaler: NB_COUNT counter with enable, clear (from i_load) and terminal compare. Outputs a one-cycle step strobe.
- The top level holds the pattern register and the direction FSM.

Test Plan:
- Reset then i_valid=1, i_limit=0, mode 00, NB_LEDS=4 -> o_led 0001, 0010, 0100, 1000, 0001 on consecutive cycles; o_tick high every cycle.
- i_limit=3, mode 01 -> one step per 4 enabled cycles: 0001 -> 1000 -> 0100. o_tick pulses 1 cycle in 4. Deasserting i_valid for 5 cycles mid-count delays the next step by exactly 5 cycles.
- Mode 10, i_limit=0, from 0001 -> 0010, 0100, 1000, 0100, 0010, 0001, 0010. o_dir goes 1 on the step producing 0100 after 1000, and 0 on the step producing 0010 after 0001.
- i_load=1 with i_pattern=0110 in the same cycle as a terminal count -> o_led=0110, o_tick=0. The next step occurs i_limit+1 enabled cycles later.
- Mode 11 for 3 steps -> o_led constant, 3 o_tick pulses. Load 0000 in mode 10 -> o_led stays 0000 and o_dir is unchanged.
- Assert i_reset low asynchronously between clock edges mid-sequence -> o_led=0001, o_tick=0, o_dir=0 immediately. Operation resumes from 0001 after release.

Source files
------------

// File: rtl/led_sequencer_pkg.sv
// Shared encodings for the LED sequencer: step modes and ping-pong directions.
package led_seq_pkg;

   // Step mode encodings, sampled from i_mode on each step
   localparam logic [1:0] MODE_ROT_L = 2'b00;
   localparam logic [1:0] MODE_ROT_R = 2'b01;
   localparam logic [1:0] MODE_PING  = 2'b10;
   localparam logic [1:0] MODE_HOLD  = 2'b11;

   // Direction FSM states; the state value is what o_dir shows
   localparam logic DIR_LEFT  = 1'b0;
   localparam logic DIR_RIGHT = 1'b1;

endpackage : led_seq_pkg

// File: rtl/led_sequencer_step_prescaler.sv
// Step prescaler: counts enabled cycles and raises a step strobe on the
// terminal count. The strobe is combinational and is registered by the
// caller, so a step becomes visible one cycle after the terminal count.
module step_prescaler #(
   parameter int NB_COUNT = 8
) (
   input  logic                clock,
   input  logic                i_reset,
   input  logic                i_enable,
   input  logic                i_clear,
   input  logic [NB_COUNT-1:0] i_limit,
   output logic                o_step
);

   logic [NB_COUNT-1:0] count;
   logic                terminal;

   // A count above a freshly lowered limit just runs on and wraps through zero
   assign terminal = (count == i_limit);

   // A clear (pattern load) always wins, so its coincident step is dropped
   assign o_step = i_enable & terminal & ~i_clear;

   // Counter update: clear, wrap on terminal, increment, or hold when disabled
   always_ff @(posedge clock or negedge i_reset) begin
      if (!i_reset) begin
         count <= {NB_COUNT{1'b0}};
      end else if (i_clear) begin
         count <= {NB_COUNT{1'b0}};
      end else if (i_enable) begin
         if (terminal) begin
            count <= {NB_COUNT{1'b0}};
         end else begin
            count <= count + {{(NB_COUNT-1){1'b0}}, 1'b1};
         end
      end else begin
         count <= count;
      end
   end

endmodule : step_prescaler

// File: rtl/led_sequencer.sv
// LED sequencer top: a prescaled step engine that rotates, bounces or holds
// a loadable NB_LEDS-wide pattern. All outputs come straight from flops.
module led_sequencer
   import led_seq_pkg::*;
#(
   parameter int NB_LEDS  = 4,
   parameter int NB_COUNT = 8
) (
   input  logic                clock,
   input  logic                i_reset,
   input  logic                i_valid,
   input  logic [1:0]          i_mode,
   input  logic [NB_COUNT-1:0] i_limit,
   input  logic                i_load,
   input  logic [NB_LEDS-1:0]  i_pattern,
   output logic [NB_LEDS-1:0]  o_led,
   output logic                o_tick,
   output logic                o_dir
);

   logic               step;
   logic [NB_LEDS-1:0] led;
   logic               dir;
   logic               tick;
   logic [NB_LEDS-1:0] led_next;
   logic               dir_next;

   step_prescaler #(
      .NB_COUNT (NB_COUNT)
   ) u_prescaler (
      .clock    (clock),
      .i_reset  (i_reset),
      .i_enable (i_valid),
      .i_clear  (i_load),
      .i_limit  (i_limit),
      .o_step   (step)
   );

   // Next pattern and direction for a step; ping-pong uses zero-filled shifts
   always_comb begin
      led_next = led;
      dir_next = dir;
      case (i_mode)
         MODE_ROT_L: begin
            led_next = {led[NB_LEDS-2:0], led[NB_LEDS-1]};
            dir_next = DIR_LEFT;
         end
         MODE_ROT_R: begin
            led_next = {led[0], led[NB_LEDS-1:1]};
            dir_next = DIR_RIGHT;
         end
         MODE_PING: begin
            if (dir == DIR_LEFT) begin
               if (led[NB_LEDS-1]) begin
                  dir_next = DIR_RIGHT;
                  led_next = {1'b0, led[NB_LEDS-1:1]};
               end else begin
                  dir_next = DIR_LEFT;
                  led_next = {led[NB_LEDS-2:0], 1'b0};
               end
            end else begin
               if (led[0]) begin
                  dir_next = DIR_LEFT;
                  led_next = {led[NB_LEDS-2:0], 1'b0};
               end else begin
                  dir_next = DIR_RIGHT;
                  led_next = {1'b0, led[NB_LEDS-1:1]};
               end
            end
         end
         MODE_HOLD: begin
            led_next = led;
            dir_next = dir;
         end
         default: begin
            led_next = led;
            dir_next = dir;
         end
      endcase
   end

   // Pattern, direction and tick registers; a load overrides any pending step
   always_ff @(posedge clock or negedge i_reset) begin
      if (!i_reset) begin
         led  <= {{(NB_LEDS-1){1'b0}}, 1'b1};
         dir  <= DIR_LEFT;
         tick <= 1'b0;
      end else if (i_load) begin
         led  <= i_pattern;
         dir  <= dir;
         tick <= 1'b0;
      end else if (step) begin
         led  <= led_next;
         dir  <= dir_next;
         tick <= 1'b1;
      end else begin
         led  <= led;
         dir  <= dir;
         tick <= 1'b0;
      end
   end

   assign o_led  = led;
   assign o_dir  = dir;
   assign o_tick = tick;

endmodule : led_sequencer

// File: tb/tb_led_sequencer.sv
// Self-checking bench for led_sequencer: directed scenarios with literal
// expectations, then randomized traffic against a behavioural model.
module tb_led_sequencer;

   localparam int N = 4;
   localparam int C = 8;

   logic         clock = 1'b0;
   logic         i_reset;
   logic         i_valid;
   logic [1:0]   i_mode;
   logic [C-1:0] i_limit;
   logic         i_load;
   logic [N-1:0] i_pattern;
   logic [N-1:0] o_led;
   logic         o_tick;
   logic         o_dir;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int last_tick_cyc = 0;

   // behavioural model state
   logic [N-1:0] m_led;
   int           m_cnt;
   logic         m_tick;
   logic         m_dir;

   always #5 clock = ~clock;

   led_sequencer #(.NB_LEDS(N), .NB_COUNT(C)) dut (
      .clock     (clock),
      .i_reset   (i_reset),
      .i_valid   (i_valid),
      .i_mode    (i_mode),
      .i_limit   (i_limit),
      .i_load    (i_load),
      .i_pattern (i_pattern),
      .o_led     (o_led),
      .o_tick    (o_tick),
      .o_dir     (o_dir)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
      end
   endtask

   task automatic model_reset();
      m_led  = 4'b0001;
      m_cnt  = 0;
      m_tick = 1'b0;
      m_dir  = 1'b0;
   endtask

   // one step of the pattern, described as integer arithmetic on the LED value
   task automatic model_apply();
      int v;
      int full;
      full = 1 << N;
      v = int'(m_led);
      case (i_mode)
         2'd0: begin v = ((v * 2) % full) | (v >> (N - 1)); m_dir = 1'b0; end
         2'd1: begin v = (v >> 1) | ((v % 2) << (N - 1)); m_dir = 1'b1; end
         2'd2: begin
            if (m_dir == 1'b0) begin
               if (v >= (full / 2)) begin m_dir = 1'b1; v = v / 2; end
               else v = (v * 2) % full;
            end else begin
               if ((v % 2) == 1) begin m_dir = 1'b0; v = (v * 2) % full; end
               else v = v / 2;
            end
         end
         default: ;
      endcase
      m_led = v[N-1:0];
   endtask

   task automatic model_clock();
      if (!i_reset) model_reset();
      else if (i_load) begin
         m_led = i_pattern; m_cnt = 0; m_tick = 1'b0;
      end else if (i_valid && m_cnt == int'(i_limit)) begin
         m_cnt = 0; m_tick = 1'b1; model_apply();
      end else begin
         m_tick = 1'b0;
         if (i_valid) m_cnt = (m_cnt + 1) % (1 << C);
      end
   endtask

   task automatic check_all();
      chk("led", 32'(o_led), 32'(m_led));
      chk("tick", 32'(o_tick), 32'(m_tick));
      chk("dir", 32'(o_dir), 32'(m_dir));
   endtask

   // advance one clock, update model, compare away from the edge
   task automatic step_cycle();
      @(posedge clock);
      model_clock();
      cyc++;
      #1;
      check_all();
   endtask

   // literal expectation pinning both DUT and model
   task automatic lit(input string name, input logic [N-1:0] led, input logic tick, input logic dir);
      chk({name, "_led"}, 32'(o_led), 32'(led));
      chk({name, "_tick"}, 32'(o_tick), 32'(tick));
      chk({name, "_dir"}, 32'(o_dir), 32'(dir));
      chk({name, "_model"}, 32'(m_led), 32'(led));
   endtask

   task automatic wait_tick(input string name, input int exp_gap);
      int k;
      for (k = 0; k < 40; k++) begin
         step_cycle();
         if (o_tick === 1'b1) break;
      end
      chk(name, 32'(cyc - last_tick_cyc), 32'(exp_gap));
      last_tick_cyc = cyc;
   endtask

   task automatic async_reset();
      i_reset = 1'b0;
      #1;
      model_reset();
      check_all();
   endtask

   initial begin
      i_reset = 1'b0; i_valid = 1'b0; i_mode = 2'd0; i_limit = 8'd0;
      i_load = 1'b0; i_pattern = 4'b0000;
      model_reset();
      repeat (3) step_cycle();
      lit("reset", 4'b0001, 1'b0, 1'b0);

      // rotate left every cycle
      i_valid = 1'b1; i_limit = 8'd0; i_mode = 2'd0; i_reset = 1'b1;
      step_cycle(); lit("rotl1", 4'b0010, 1'b1, 1'b0);
      step_cycle(); lit("rotl2", 4'b0100, 1'b1, 1'b0);
      step_cycle(); lit("rotl3", 4'b1000, 1'b1, 1'b0);
      step_cycle(); lit("rotl4", 4'b0001, 1'b1, 1'b0);

      // rotate right with prescale 4, then a 5-cycle enable gap
      async_reset();
      lit("async0", 4'b0001, 1'b0, 1'b0);
      i_limit = 8'd3; i_mode = 2'd1;
      step_cycle();
      i_reset = 1'b1; last_tick_cyc = cyc;
      wait_tick("gap4a", 4); lit("rotr1", 4'b1000, 1'b1, 1'b1);
      wait_tick("gap4b", 4); lit("rotr2", 4'b0100, 1'b1, 1'b1);
      step_cycle(); step_cycle();
      i_valid = 1'b0;
      repeat (5) step_cycle();
      i_valid = 1'b1;
      wait_tick("gap9", 9); lit("rotr3", 4'b0010, 1'b1, 1'b1);

      // ping-pong from 0001
      async_reset();
      i_limit = 8'd0; i_mode = 2'd2;
      step_cycle();
      i_reset = 1'b1;
      step_cycle(); lit("ping1", 4'b0010, 1'b1, 1'b0);
      step_cycle(); lit("ping2", 4'b0100, 1'b1, 1'b0);
      step_cycle(); lit("ping3", 4'b1000, 1'b1, 1'b0);
      step_cycle(); lit("ping4", 4'b0100, 1'b1, 1'b1);
      step_cycle(); lit("ping5", 4'b0010, 1'b1, 1'b1);
      step_cycle(); lit("ping6", 4'b0001, 1'b1, 1'b1);
      step_cycle(); lit("ping7", 4'b0010, 1'b1, 1'b0);

      // load coincident with terminal count drops the step
      async_reset();
      i_limit = 8'd3; i_mode = 2'd0;
      step_cycle();
      i_reset = 1'b1;
      repeat (3) step_cycle();
      i_load = 1'b1; i_pattern = 4'b0110;
      step_cycle(); lit("load", 4'b0110, 1'b0, 1'b0);
      i_load = 1'b0; last_tick_cyc = cyc;
      wait_tick("loadgap", 4); lit("afterload", 4'b1100, 1'b1, 1'b0);

      // hold for three steps, then a zero pattern in ping-pong
      i_limit = 8'd0; i_mode = 2'd1;
      step_cycle(); lit("r1", 4'b0110, 1'b1, 1'b1);
      i_mode = 2'd3;
      for (int i = 0; i < 3; i++) begin
         step_cycle(); lit("hold", 4'b0110, 1'b1, 1'b1);
      end
      i_load = 1'b1; i_pattern = 4'b0000; i_mode = 2'd2;
      step_cycle(); lit("zload", 4'b0000, 1'b0, 1'b1);
      i_load = 1'b0;
      for (int i = 0; i < 5; i++) begin
         step_cycle(); lit("zero", 4'b0000, 1'b1, 1'b1);
      end

      // asynchronous reset during a tick cycle
      i_load = 1'b1; i_pattern = 4'b0100;
      step_cycle();
      i_load = 1'b0;
      step_cycle(); lit("pre_rst", 4'b0010, 1'b1, 1'b1);
      async_reset();
      lit("mid_rst", 4'b0001, 1'b0, 1'b0);
      step_cycle(); step_cycle();
      i_reset = 1'b1; i_mode = 2'd0;
      step_cycle(); lit("resume", 4'b0010, 1'b1, 1'b0);

      // randomized traffic
      for (int i = 0; i < 1500; i++) begin
         i_valid   = ($urandom % 4) != 0;
         i_load    = ($urandom % 16) == 0;
         i_pattern = 4'($urandom);
         if (($urandom % 8) == 0) i_mode = 2'($urandom);
         if (($urandom % 32) == 0) i_limit = 8'($urandom_range(0, 3));
         else if (($urandom % 300) == 0) i_limit = 8'($urandom);
         if (($urandom % 200) == 0) async_reset();
         else i_reset = 1'b1;
         step_cycle();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule : tb_led_sequencer
